// File: rtl/valu_pkg.sv
// valu_pkg: operation/element-width encodings, FSM state type and the
// legality helper shared by the vector-ALU arbiter and its users.
package valu_pkg;

   localparam logic [1:0] OP_VADD = 2'b00;
   localparam logic [1:0] OP_VSUB = 2'b01;
   localparam logic [1:0] OP_VMUL = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

   localparam logic [1:0] SEW_8   = 2'b00;
   localparam logic [1:0] SEW_16  = 2'b01;
   localparam logic [1:0] SEW_32  = 2'b10;
   localparam logic [1:0] SEW_ILL = 2'b11;

   // Cycles an operation may spend waiting on the ALU before it is aborted
   localparam int TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // An encoding is legal only if both the operation and element width are
   function automatic logic is_legal(input logic [1:0] op, input logic [1:0] sew);
      return (op != OP_ILL) && (sew != SEW_ILL);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick. The caller owns and
// registers last_grant; this block only decides who wins this cycle.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

   // When both ask, the one that did not win last time goes next
   always_comb begin
      // NOTE: every output is given a default first so no path can leave it unassigned and infer a latch.
      grant       = 1'b0;
      grant_valid = |req;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/valu_arbiter.sv
// valu_arbiter: shares one vector ALU between two issue ports. Accepts one
// request at a time, rejects illegal encodings without touching the ALU,
// drives the start-pulse / hold-operands / done protocol, and holds the
// result until the response consumer takes it.
module valu_arbiter
   import valu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [1:0]  r0_op,
   input  logic [1:0]  r0_sew,
   input  logic [63:0] r0_vs1,
   input  logic [63:0] r0_vs2,

   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [1:0]  r1_op,
   input  logic [1:0]  r1_sew,
   input  logic [63:0] r1_vs1,
   input  logic [63:0] r1_vs2,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic        rsp_err,
   output logic [63:0] rsp_data,

   output logic [1:0]  alu_op,
   output logic [1:0]  alu_sew,
   output logic [63:0] alu_vs1,
   output logic [63:0] alu_vs2,
   output logic        alu_valid_in,
   input  logic        alu_valid_out,
   input  logic [63:0] alu_result,

   output logic        busy
);

   localparam int                CNT_W     = $clog2(TIMEOUT + 1);
   // Last WAIT cycle before giving up: the counter starts at 0 on entry
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] wait_cnt;

   logic             grant;
   logic             grant_valid;
   logic             accept;

   logic [1:0]       sel_op;
   logic [1:0]       sel_sew;
   logic [63:0]      sel_vs1;
   logic [63:0]      sel_vs2;

   rr_arb2 u_arb (
      .req         ({r1_valid, r0_valid}),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Ready only in IDLE and only to the valid requester that won
   assign accept   = (state == IDLE) && grant_valid;
   assign r0_ready = accept && !grant;
   assign r1_ready = accept &&  grant;
   assign busy     = (state != IDLE);

   // Payload of the winning port
   assign sel_op  = grant ? r1_op  : r0_op;
   assign sel_sew = grant ? r1_sew : r0_sew;
   assign sel_vs1 = grant ? r1_vs1 : r0_vs1;
   assign sel_vs2 = grant ? r1_vs2 : r0_vs2;

   // Control FSM plus the ALU-side and response registers it owns
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         wait_cnt     <= '0;
         alu_op       <= '0;
         alu_sew      <= '0;
         alu_vs1      <= '0;
         alu_vs2      <= '0;
         alu_valid_in <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_data     <= '0;
      end else begin
         // The start pulse is only ever set for the single ISSUE cycle
         alu_valid_in <= 1'b0;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_op     <= sel_op;
                  alu_sew    <= sel_sew;
                  alu_vs1    <= sel_vs1;
                  alu_vs2    <= sel_vs2;
                  rsp_id     <= grant;
                  last_grant <= grant;
                  if (!is_legal(sel_op, sel_sew)) begin
                     // Reject without starting the ALU
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     alu_valid_in <= 1'b1;
                     state        <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end

            WAIT: begin
               // Operands stay put here: the ALU re-reads them every cycle
               if (alu_valid_out) begin
                  rsp_data  <= alu_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_valu_arbiter.sv
// tb_valu_arbiter: drives both issue ports, models a variable-latency
// vector ALU, and scores every response (id, err, data, latency) plus the
// start-pulse and operand-hold protocol on the ALU side.
module tb_valu_arbiter;
   import valu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [1:0]  rq_valid;
   logic [1:0]  rq_op  [2];
   logic [1:0]  rq_sew [2];
   logic [63:0] rq_vs1 [2];
   logic [63:0] rq_vs2 [2];
   logic        r0_ready, r1_ready;
   logic [1:0]  rq_ready;

   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [63:0] rsp_data;
   logic [1:0]  alu_op, alu_sew;
   logic [63:0] alu_vs1, alu_vs2, alu_result;
   logic        alu_valid_in, alu_valid_out;
   logic        busy;

   assign rq_ready = {r1_ready, r0_ready};

   always #5 clk = ~clk;

   valu_arbiter #(.TIMEOUT(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_valid      (rq_valid[0]),
      .r0_ready      (r0_ready),
      .r0_op         (rq_op[0]),
      .r0_sew        (rq_sew[0]),
      .r0_vs1        (rq_vs1[0]),
      .r0_vs2        (rq_vs2[0]),
      .r1_valid      (rq_valid[1]),
      .r1_ready      (r1_ready),
      .r1_op         (rq_op[1]),
      .r1_sew        (rq_sew[1]),
      .r1_vs1        (rq_vs1[1]),
      .r1_vs2        (rq_vs2[1]),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_err       (rsp_err),
      .rsp_data      (rsp_data),
      .alu_op        (alu_op),
      .alu_sew       (alu_sew),
      .alu_vs1       (alu_vs1),
      .alu_vs2       (alu_vs2),
      .alu_valid_in  (alu_valid_in),
      .alu_valid_out (alu_valid_out),
      .alu_result    (alu_result),
      .busy          (busy)
   );

   // ---------------------------------------------------------------- checks
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
   endtask

   // Lane-wise reference arithmetic used by the ALU model and for expectations
   function automatic logic [63:0] alu_f(input logic [1:0] op, input logic [1:0] sew,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r, m, x, y, z;
      int ew;
      if (sew == SEW_ILL) return '0;
      ew = 8 << sew;
      m  = (64'd1 << ew) - 64'd1;
      r  = '0;
      for (int i = 0; i < 64 / ew; i++) begin
         x = (a >> (i * ew)) & m;
         y = (b >> (i * ew)) & m;
         case (op)
            OP_VADD: z = x + y;
            OP_VSUB: z = x - y;
            default: z = x * y;
         endcase
         r = r | ((z & m) << (i * ew));
      end
      return r;
   endfunction

   // ------------------------------------------------------------ ALU model
   // Done follows the start sample by 0 extra edges for add/sub, 2 for
   // e16/e32 multiply and 4 for e8 multiply; alu_mute stubs out the answer.
   logic alu_mute;
   int   alu_rem;

   always @(posedge clk) begin
      if (!rst_n) begin
         alu_valid_out <= 1'b0;
         alu_result    <= '0;
         alu_rem       <= 0;
      end else begin
         alu_valid_out <= 1'b0;
         if (alu_valid_in) begin
            if (alu_op == OP_VMUL) alu_rem <= (alu_sew == SEW_8) ? 4 : 2;
            else begin
               alu_valid_out <= !alu_mute;
               alu_result    <= alu_f(alu_op, alu_sew, alu_vs1, alu_vs2);
            end
         end else if (alu_rem != 0) begin
            alu_rem <= alu_rem - 1;
            if (alu_rem == 1) begin
               alu_valid_out <= !alu_mute;
               alu_result    <= alu_f(alu_op, alu_sew, alu_vs1, alu_vs2);
            end
         end
      end
   end

   // ----------------------------------------------------------- scoreboard
   typedef struct {
      logic        id;
      logic [1:0]  op;
      logic [1:0]  sew;
      logic [63:0] vs1;
      logic [63:0] vs2;
      logic [63:0] data;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t pend0[$];
   exp_t pend1[$];
   exp_t sb[$];
   logic gseq[$];
   int   acc_q[$];

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t        me;
   logic        got_e;
   logic        rsp_prev = 1'b0;
   logic        vin_prev = 1'b0;
   logic        in_flight = 1'b0;
   int          first_rsp = 0;
   int          n_starts = 0;
   logic [3:0]  cap_opsew;
   logic [63:0] cap_vs1, cap_vs2;

   // Sample everything on the falling edge, away from the DUT's active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         in_flight = 1'b0;
         rsp_prev  = 1'b0;
         vin_prev  = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (rq_ready[p]) begin
               check("ready_only_when_valid", rq_valid[p], 1);
               if (rq_valid[p]) begin
                  got_e = 1'b0;
                  if (p == 0 && pend0.size() != 0) begin me = pend0.pop_front(); got_e = 1'b1; end
                  if (p == 1 && pend1.size() != 0) begin me = pend1.pop_front(); got_e = 1'b1; end
                  check("accept_has_stimulus", got_e, 1);
                  if (got_e) begin
                     me.acc = cyc + 1;
                     sb.push_back(me);
                  end
                  gseq.push_back(p[0]);
                  acc_q.push_back(cyc + 1);
               end
            end
         end

         if (alu_valid_in) begin
            check("start_single_pulse", vin_prev, 0);
            n_starts++;
            if (sb.size() != 0) begin
               check("alu_opsew", {alu_op, alu_sew}, {sb[0].op, sb[0].sew});
               check("alu_vs1", alu_vs1, sb[0].vs1);
               check("alu_vs2", alu_vs2, sb[0].vs2);
            end
            cap_opsew = {alu_op, alu_sew};
            cap_vs1   = alu_vs1;
            cap_vs2   = alu_vs2;
            in_flight = 1'b1;
         end else if (in_flight && busy && !rsp_valid) begin
            check("hold_opsew", {alu_op, alu_sew}, cap_opsew);
            check("hold_vs1", alu_vs1, cap_vs1);
            check("hold_vs2", alu_vs2, cap_vs2);
         end

         if (rsp_valid && !rsp_prev) first_rsp = cyc + 1;
         if (rsp_valid && rsp_ready) begin
            check("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               me = sb.pop_front();
               check("rsp_id", rsp_id, me.id);
               check("rsp_err", rsp_err, me.err);
               check("rsp_data", rsp_data, me.data);
               check("rsp_latency", first_rsp - me.acc, me.lat);
            end
            in_flight = 1'b0;
         end
         rsp_prev = rsp_valid;
         vin_prev = alu_valid_in;
      end
   end

   // ------------------------------------------------------------- drivers
   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input int p, input logic [1:0] op, input logic [1:0] sew,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ed, input logic ee, input int el);
      exp_t e;
      int   n;
      e = '{id: p[0], op: op, sew: sew, vs1: a, vs2: b, data: ed, err: ee, lat: el, acc: 0};
      if (p == 0) pend0.push_back(e); else pend1.push_back(e);
      rq_op[p]    = op;
      rq_sew[p]   = sew;
      rq_vs1[p]   = a;
      rq_vs2[p]   = b;
      rq_valid[p] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rq_ready[p] && n < 200);
      check("send_accepted", rq_ready[p], 1);
      @(posedge clk);
      #1 rq_valid[p] = 1'b0;
   endtask

   task automatic wait_idle();
      int   n;
      logic idle;
      n = 0;
      do begin
         @(negedge clk);
         idle = (sb.size() == 0) && (pend0.size() == 0) && (pend1.size() == 0) && !busy && !rsp_valid;
         n++;
      end while (!idle && n < 400);
      check("drained", idle, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctl"}, {rsp_valid, rsp_err, rsp_id, busy, alu_valid_in,
                            r0_ready, r1_ready, alu_op, alu_sew}, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_alu_vs1"}, alu_vs1, 0);
      check({tag, "_alu_vs2"}, alu_vs2, 0);
   endtask

   // -------------------------------------------------------- vector table
   typedef struct {
      int          port;
      logic [1:0]  op;
      logic [1:0]  sew;
      logic [63:0] vs1;
      logic [63:0] vs2;
      logic [63:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vt [9];
   int   s0, g0, hs_edge, nw;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{0, OP_VADD, SEW_8,   64'h7F40_2010_0804_0201, 64'h0101_0101_0101_0101, 64'h8041_2111_0905_0302, 1'b0, 3};
      vt[1] = '{1, OP_VMUL, SEW_8,   64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303, 64'h0606_0606_0606_0606, 1'b0, 7};
      vt[2] = '{0, OP_VSUB, SEW_16,  64'h0000_0001_8000_1234, 64'h0001_0002_0001_0234, 64'hFFFF_FFFF_7FFF_1000, 1'b0, 3};
      vt[3] = '{1, OP_VMUL, SEW_32,  64'h0000_0003_0001_0000, 64'h0000_0005_0001_0000, 64'h0000_000F_0000_0000, 1'b0, 5};
      vt[4] = '{0, OP_VADD, SEW_32,  64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0, 3};
      vt[5] = '{1, OP_VMUL, SEW_16,  64'h00FF_0100_0002_FFFF, 64'h00FF_0100_0003_FFFF, 64'hFE01_0000_0006_0001, 1'b0, 5};
      vt[6] = '{0, OP_ILL,  SEW_8,   64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0,                  1'b1, 1};
      vt[7] = '{1, OP_VADD, SEW_ILL, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0,                  1'b1, 1};
      vt[8] = '{1, OP_VSUB, SEW_8,   64'h0000_0000_0000_0000, 64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3};

      rst_n     = 1'b0;
      rq_valid  = '0;
      for (int p = 0; p < 2; p++) begin
         rq_op[p]  = '0;
         rq_sew[p] = '0;
         rq_vs1[p] = '0;
         rq_vs2[p] = '0;
      end
      rsp_ready = 1'b1;
      alu_mute  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single operations from the table, one at a time
      for (int i = 0; i < 9; i++) begin
         s0 = n_starts;
         send(vt[i].port, vt[i].op, vt[i].sew, vt[i].vs1, vt[i].vs2,
              vt[i].exp_data, vt[i].exp_err, vt[i].exp_lat);
         wait_idle();
         check(vt[i].exp_err ? "illegal_no_start" : "one_start", n_starts - s0, vt[i].exp_err ? 0 : 1);
      end

      // Both ports held valid: grants alternate r0, r1, ... one op per 4 cycles
      g0 = gseq.size();
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               logic [63:0] a, b;
               a = {32'h0000_1000 + 32'(k), 32'h8000_0000};
               b = {32'h0000_0001, 32'h0000_0001 + 32'(k)};
               send(0, OP_VSUB, SEW_32, a, b, alu_f(OP_VSUB, SEW_32, a, b), 1'b0, 3);
            end
         end
         begin
            for (int k = 0; k < 4; k++) begin
               logic [63:0] a, b;
               a = {32'h0000_0000, 32'h0000_0010 + 32'(k)};
               b = {32'h0000_0002, 32'h0000_0020};
               send(1, OP_VSUB, SEW_32, a, b, alu_f(OP_VSUB, SEW_32, a, b), 1'b0, 3);
            end
         end
      join
      wait_idle();
      check("alt_grant_count", gseq.size() - g0, 8);
      if (gseq.size() >= g0 + 8) begin
         for (int k = 0; k < 8; k++) begin
            check("alt_grant_order", gseq[g0 + k], k % 2);
            if (k > 0) check("alt_accept_spacing", acc_q[g0 + k] - acc_q[g0 + k - 1], 4);
         end
      end

      // Response backpressure with a second requester waiting
      rsp_ready = 1'b0;
      hs_edge   = 0;
      fork
         begin
            send(0, OP_VMUL, SEW_16, 64'h0004_0003_0002_0001, 64'h0004_0004_0004_0004,
                 64'h0010_000C_0008_0004, 1'b0, 5);
            nw = 0;
            do begin
               @(negedge clk);
               nw++;
            end while (!rsp_valid && nw < 50);
            check("bp_rsp_seen", rsp_valid, 1);
            for (int k = 0; k < 10; k++) begin
               check("bp_valid_hold", rsp_valid, 1);
               check("bp_data_hold", rsp_data, 64'h0010_000C_0008_0004);
               check("bp_no_accept", rq_ready, 0);
               @(negedge clk);
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            hs_edge = cyc + 1;
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            send(1, OP_VADD, SEW_16, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040,
                 64'h0011_0022_0033_0044, 1'b0, 3);
         end
      join
      wait_idle();
      check("bp_next_accept", acc_q[$] - hs_edge, 1);

      // ALU that never answers
      alu_mute = 1'b1;
      send(0, OP_VADD, SEW_8, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'h0, 1'b1, 17);
      wait_idle();
      alu_mute = 1'b0;

      // Reset while waiting on a long multiply
      send(0, OP_VMUL, SEW_8, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
           64'h0606_0606_0606_0606, 1'b0, 7);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_in_wait", {busy, rsp_valid, alu_valid_in}, 3'b100);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("mid_wait_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // After reset r0 wins a simultaneous request first
      g0 = gseq.size();
      fork
         send(0, OP_VADD, SEW_16, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0, 1'b0, 3);
         send(1, OP_VADD, SEW_8,  64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0002, 64'h1, 1'b0, 3);
      join
      wait_idle();
      check("post_reset_grant_count", gseq.size() - g0, 2);
      if (gseq.size() >= g0 + 2) begin
         check("post_reset_first_grant", gseq[g0], 0);
         check("post_reset_second_grant", gseq[g0 + 1], 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
